// File: rtl/prim_sram_arbiter_rr.sv
// Round-robin arbiter that lets N requesters share one SRAM port, with a steering FIFO that routes read data back to the right requester.
// Define PRIM_SRAM_ARB_ERR_CHECK_EN to add the sticky err_o flag for read data that arrives with no read outstanding.
module prim_sram_arbiter_rr #(
  parameter int N           = 4,
  parameter int SramDw      = 32,
  parameter int SramAw      = 12,
  parameter int Outstanding = 4,
  localparam int CntW       = $clog2(Outstanding + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [N-1:0]      req_i,
  input  logic [SramAw-1:0] req_addr_i  [N],
  input  logic              req_write_i [N],
  input  logic [SramDw-1:0] req_wdata_i [N],
  input  logic [SramDw-1:0] req_wmask_i [N],
  output logic [N-1:0]      gnt_o,
  output logic [N-1:0]      rsp_rvalid_o,
  output logic [SramDw-1:0] rsp_rdata_o [N],
  output logic [1:0]        rsp_error_o [N],
  output logic              sram_req_o,
  output logic [SramAw-1:0] sram_addr_o,
  output logic              sram_write_o,
  output logic [SramDw-1:0] sram_wdata_o,
  output logic [SramDw-1:0] sram_wmask_o,
  input  logic              sram_rvalid_i,
  input  logic [SramDw-1:0] sram_rdata_i,
  input  logic [1:0]        sram_rerror_i,
`ifdef PRIM_SRAM_ARB_ERR_CHECK_EN
  output logic              err_o,
`endif
  output logic [CntW-1:0]   outstanding_o
);

  localparam int PtrW   = $clog2(N);
  localparam int FifoAw = (Outstanding > 1) ? $clog2(Outstanding) : 1;

  logic [PtrW-1:0]   prio_q;
  logic [PtrW-1:0]   gnt_idx;
  logic [N-1:0]      eligible;
  logic [N-1:0]      gnt;
  logic              found;
  logic              any_gnt;
  logic              push;
  logic              pop;
  logic              read_slot;
  logic [N-1:0]      steer_q [Outstanding];
  logic [FifoAw-1:0] wr_ptr_q;
  logic [FifoAw-1:0] rd_ptr_q;
  logic [CntW-1:0]   count_q;

  // A full FIFO still accepts a read when its head retires in the same cycle.
  assign pop       = sram_rvalid_i && (count_q != '0);
  assign read_slot = (count_q < CntW'(Outstanding)) || pop;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      eligible[i] = req_i[i] && (req_write_i[i] || read_slot);
    end
  end

  // Two passes give the wrap-around search order p .. N-1, then 0 .. p-1.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && (i >= int'(prio_q)) && eligible[i]) begin
        gnt[i]  = 1'b1;
        gnt_idx = PtrW'(i);
        found   = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && (i < int'(prio_q)) && eligible[i]) begin
        gnt[i]  = 1'b1;
        gnt_idx = PtrW'(i);
        found   = 1'b1;
      end
    end
    if (!rst_ni) begin
      gnt = '0;
    end
  end

  assign gnt_o      = gnt;
  assign any_gnt    = |gnt;
  assign sram_req_o = any_gnt;

  always_comb begin
    sram_addr_o  = '0;
    sram_write_o = 1'b0;
    sram_wdata_o = '0;
    sram_wmask_o = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        sram_addr_o  = req_addr_i[i];
        sram_write_o = req_write_i[i];
        sram_wdata_o = req_wdata_i[i];
        sram_wmask_o = req_wmask_i[i];
      end
    end
  end

  assign push = any_gnt && !sram_write_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (any_gnt) begin
        prio_q <= (gnt_idx == PtrW'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == FifoAw'(Outstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == FifoAw'(Outstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Steering entries need no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push) begin
      steer_q[wr_ptr_q] <= gnt;
    end
  end

  assign rsp_rvalid_o  = steer_q[rd_ptr_q] & {N{pop}};
  assign outstanding_o = count_q;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      rsp_rdata_o[i] = sram_rdata_i;
      rsp_error_o[i] = sram_rerror_i;
    end
  end

`ifdef PRIM_SRAM_ARB_ERR_CHECK_EN
  logic err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (sram_rvalid_i && (count_q == '0)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_prim_sram_arbiter_rr.sv
// Scoreboard bench for prim_sram_arbiter_rr: stimulus queues expected grants and read responses, a negedge monitor retires them.
// Build with PRIM_SRAM_ARB_ERR_CHECK_EN to also check the sticky err_o flag.
module tb_prim_sram_arbiter_rr;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int AW   = 12;
  localparam int OUTS = 4;
  localparam int CW   = $clog2(OUTS + 1);

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [N-1:0]  req_i;
  logic [AW-1:0] req_addr_i  [N];
  logic          req_write_i [N];
  logic [DW-1:0] req_wdata_i [N];
  logic [DW-1:0] req_wmask_i [N];
  logic [N-1:0]  gnt_o;
  logic [N-1:0]  rsp_rvalid_o;
  logic [DW-1:0] rsp_rdata_o [N];
  logic [1:0]    rsp_error_o [N];
  logic          sram_req_o;
  logic [AW-1:0] sram_addr_o;
  logic          sram_write_o;
  logic [DW-1:0] sram_wdata_o;
  logic [DW-1:0] sram_wmask_o;
  logic          sram_rvalid_i;
  logic [DW-1:0] sram_rdata_i;
  logic [1:0]    sram_rerror_i;
  logic [CW-1:0] outstanding_o;
`ifdef PRIM_SRAM_ARB_ERR_CHECK_EN
  logic          err_o;
`endif

  typedef struct {
    logic [N-1:0]  gnt;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] wmask;
  } grant_t;

  typedef struct {
    logic [N-1:0]  port;
    logic [DW-1:0] data;
    logic [1:0]    err;
  } rsp_t;

  grant_t grant_q [$];
  rsp_t   rsp_q [$];
  int     n_compared = 0;
  int     n_mismatch = 0;

  prim_sram_arbiter_rr #(
    .N(N), .SramDw(DW), .SramAw(AW), .Outstanding(OUTS)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_i         (req_i),
    .req_addr_i    (req_addr_i),
    .req_write_i   (req_write_i),
    .req_wdata_i   (req_wdata_i),
    .req_wmask_i   (req_wmask_i),
    .gnt_o         (gnt_o),
    .rsp_rvalid_o  (rsp_rvalid_o),
    .rsp_rdata_o   (rsp_rdata_o),
    .rsp_error_o   (rsp_error_o),
    .sram_req_o    (sram_req_o),
    .sram_addr_o   (sram_addr_o),
    .sram_write_o  (sram_write_o),
    .sram_wdata_o  (sram_wdata_o),
    .sram_wmask_o  (sram_wmask_o),
    .sram_rvalid_i (sram_rvalid_i),
    .sram_rdata_i  (sram_rdata_i),
    .sram_rerror_i (sram_rerror_i),
`ifdef PRIM_SRAM_ARB_ERR_CHECK_EN
    .err_o         (err_o),
`endif
    .outstanding_o (outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: retire one expected grant per SRAM request and one expected response per rvalid pulse.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (sram_req_o) begin
        if (grant_q.size() == 0) begin
          check_output("unexpected_grant", 64'(gnt_o), 64'(0));
        end else begin
          grant_t g;
          g = grant_q.pop_front();
          check_output("gnt", 64'(gnt_o), 64'(g.gnt));
          check_output("sram_write", 64'(sram_write_o), 64'(g.write));
          check_output("sram_addr", 64'(sram_addr_o), 64'(g.addr));
          check_output("sram_wdata", 64'(sram_wdata_o), 64'(g.wdata));
          check_output("sram_wmask", 64'(sram_wmask_o), 64'(g.wmask));
        end
      end
      if (|rsp_rvalid_o) begin
        if (rsp_q.size() == 0) begin
          check_output("unexpected_rvalid", 64'(rsp_rvalid_o), 64'(0));
        end else begin
          rsp_t r;
          r = rsp_q.pop_front();
          check_output("rsp_rvalid", 64'(rsp_rvalid_o), 64'(r.port));
          for (int i = 0; i < N; i++) begin
            check_output($sformatf("rsp_rdata[%0d]", i), 64'(rsp_rdata_o[i]), 64'(r.data));
            check_output($sformatf("rsp_error[%0d]", i), 64'(rsp_error_o[i]), 64'(r.err));
          end
        end
      end
    end
  end

  task automatic clear_inputs();
    req_i         = '0;
    sram_rvalid_i = 1'b0;
    sram_rdata_i  = '0;
    sram_rerror_i = '0;
    for (int i = 0; i < N; i++) begin
      req_addr_i[i]  = '0;
      req_write_i[i] = 1'b0;
      req_wdata_i[i] = '0;
      req_wmask_i[i] = '0;
    end
  endtask

  task automatic set_read(input int port, input logic [AW-1:0] addr);
    req_i[port]       = 1'b1;
    req_write_i[port] = 1'b0;
    req_addr_i[port]  = addr;
  endtask

  task automatic set_write(input int port, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    req_i[port]       = 1'b1;
    req_write_i[port] = 1'b1;
    req_addr_i[port]  = addr;
    req_wdata_i[port] = wdata;
    req_wmask_i[port] = '1;
  endtask

  task automatic set_rvalid(input logic [DW-1:0] data, input logic [1:0] err);
    sram_rvalid_i = 1'b1;
    sram_rdata_i  = data;
    sram_rerror_i = err;
  endtask

  task automatic exp_grant(input int port, input logic write, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    grant_t g;
    g.gnt       = '0;
    g.gnt[port] = 1'b1;
    g.write     = write;
    g.addr      = addr;
    g.wdata     = wdata;
    g.wmask     = write ? '1 : '0;
    grant_q.push_back(g);
  endtask

  task automatic exp_rsp(input int port, input logic [DW-1:0] data, input logic [1:0] err);
    rsp_t r;
    r.port       = '0;
    r.port[port] = 1'b1;
    r.data       = data;
    r.err        = err;
    rsp_q.push_back(r);
  endtask

  // Inputs change just after a rising edge so the negedge monitor sees a settled cycle.
  task automatic apply_stimulus();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int drain_order [4] = '{1, 2, 3, 2};

    rst_ni = 1'b0;
    clear_inputs();
    for (int i = 0; i < N; i++) set_read(i, AW'(12'h010 + i));
    set_rvalid(32'h0000_1111, 2'b00);
    #1;
    check_output("reset_gnt", 64'(gnt_o), 64'(0));
    check_output("reset_sram_req", 64'(sram_req_o), 64'(0));
    check_output("reset_rvalid", 64'(rsp_rvalid_o), 64'(0));
    check_output("reset_outstanding", 64'(outstanding_o), 64'(0));

    // Four readers, no returns: grants walk 0..3, then the FIFO is full.
    @(posedge clk_i);
    #1;
    sram_rvalid_i = 1'b0;
    rst_ni        = 1'b1;
    for (int i = 0; i < N; i++) exp_grant(i, 1'b0, AW'(12'h010 + i), '0);
    repeat (4) apply_stimulus();
    check_output("full_outstanding", 64'(outstanding_o), 64'(4));
    apply_stimulus();
    check_output("full_hold_outstanding", 64'(outstanding_o), 64'(4));

    // Full: a write still goes through while the competing read waits.
    clear_inputs();
    set_write(1, 12'h0A1, 32'hDEAD_BEEF);
    set_read(2, 12'h0A2);
    exp_grant(1, 1'b1, 12'h0A1, 32'hDEAD_BEEF);
    apply_stimulus();
    check_output("write_when_full_outstanding", 64'(outstanding_o), 64'(4));
    req_i[1] = 1'b0;
    apply_stimulus();
    check_output("read_blocked_outstanding", 64'(outstanding_o), 64'(4));

    // Full with a return in the same cycle: read accepted, occupancy stays 4.
    set_rvalid(32'h1000_0001, 2'b00);
    exp_rsp(0, 32'h1000_0001, 2'b00);
    exp_grant(2, 1'b0, 12'h0A2, '0);
    apply_stimulus();
    check_output("push_pop_full_outstanding", 64'(outstanding_o), 64'(4));

    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      set_rvalid(32'h2000_0000 + 32'(k), 2'b00);
      exp_rsp(drain_order[k], 32'h2000_0000 + 32'(k), 2'b00);
      apply_stimulus();
    end
    clear_inputs();
    check_output("drained_outstanding", 64'(outstanding_o), 64'(0));

    // Reads from port 2 then port 0 return in issue order.
    set_read(2, 12'h200);
    exp_grant(2, 1'b0, 12'h200, '0);
    apply_stimulus();
    clear_inputs();
    set_read(0, 12'h000);
    exp_grant(0, 1'b0, 12'h000, '0);
    apply_stimulus();
    clear_inputs();
    set_rvalid(32'hA5A5_0001, 2'b00);
    exp_rsp(2, 32'hA5A5_0001, 2'b00);
    apply_stimulus();
    set_rvalid(32'hA5A5_0002, 2'b00);
    exp_rsp(0, 32'hA5A5_0002, 2'b00);
    apply_stimulus();
    clear_inputs();
    check_output("ordered_outstanding", 64'(outstanding_o), 64'(0));

    // Stray rvalid with nothing in flight is dropped.
    set_rvalid(32'h0000_0BAD, 2'b01);
    apply_stimulus();
    clear_inputs();
    check_output("stray_outstanding", 64'(outstanding_o), 64'(0));
`ifdef PRIM_SRAM_ARB_ERR_CHECK_EN
    check_output("stray_err", 64'(err_o), 64'(1));
`endif

    // Empty FIFO, grant and rvalid together: push lands, nothing pops.
    set_read(1, 12'h111);
    set_rvalid(32'h0000_0BAD, 2'b00);
    exp_grant(1, 1'b0, 12'h111, '0);
    apply_stimulus();
    clear_inputs();
    check_output("empty_push_outstanding", 64'(outstanding_o), 64'(1));
    set_rvalid(32'h5555_AAAA, 2'b10);
    exp_rsp(1, 32'h5555_AAAA, 2'b10);
    apply_stimulus();
    clear_inputs();
    check_output("empty_push_drained", 64'(outstanding_o), 64'(0));
`ifdef PRIM_SRAM_ARB_ERR_CHECK_EN
    check_output("err_sticky", 64'(err_o), 64'(1));
`endif

    // Three reads in flight, then reset mid-traffic.
    set_read(1, 12'h301);
    set_read(2, 12'h302);
    set_read(3, 12'h303);
    exp_grant(2, 1'b0, 12'h302, '0);
    exp_grant(3, 1'b0, 12'h303, '0);
    exp_grant(1, 1'b0, 12'h301, '0);
    repeat (3) apply_stimulus();
    check_output("midtraffic_outstanding", 64'(outstanding_o), 64'(3));
    rst_ni = 1'b0;
    req_i  = '1;
    set_rvalid(32'h0000_0077, 2'b00);
    #1;
    check_output("midreset_gnt", 64'(gnt_o), 64'(0));
    check_output("midreset_sram_req", 64'(sram_req_o), 64'(0));
    check_output("midreset_rvalid", 64'(rsp_rvalid_o), 64'(0));
    check_output("midreset_outstanding", 64'(outstanding_o), 64'(0));
`ifdef PRIM_SRAM_ARB_ERR_CHECK_EN
    check_output("midreset_err", 64'(err_o), 64'(0));
`endif

    @(posedge clk_i);
    #1;
    clear_inputs();
    set_read(1, 12'h401);
    set_write(3, 12'h403, 32'hCAFE_0003);
    exp_grant(1, 1'b0, 12'h401, '0);
    exp_grant(3, 1'b1, 12'h403, 32'hCAFE_0003);
    rst_ni = 1'b1;
    apply_stimulus();
    apply_stimulus();
    clear_inputs();
    check_output("post_reset_outstanding", 64'(outstanding_o), 64'(1));
    set_rvalid(32'h4444_0001, 2'b00);
    exp_rsp(1, 32'h4444_0001, 2'b00);
    apply_stimulus();
    clear_inputs();
    apply_stimulus();
    check_output("final_outstanding", 64'(outstanding_o), 64'(0));

    check_output("grants_left_unseen", 64'(grant_q.size()), 64'(0));
    check_output("responses_left_unseen", 64'(rsp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule

// File: doc/prim_sram_arbiter_rr.md
PRIM_SRAM_ARBITER_RR -- requirements
Module: prim_sram_arbiter_rr

Interface
REQ-001 SHALL have parameter N, default 4: number of requester ports (N >= 2).
REQ-002 SHALL have parameter SramDw, default 32: SRAM data width, no ECC.
REQ-003 SHALL have parameter SramAw, default 12: SRAM word-address width.
REQ-004 SHALL have parameter Outstanding, default 4: maximum reads in flight (>= 1); CntW = $clog2(Outstanding+1).
REQ-005 SHALL have port clk_i  input  1  clock; all state on rising edge.
REQ-006 SHALL have port rst_ni  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have ports req_i  input  N  request; req_addr_i  input  SramAw x [N]  address; req_write_i  input  1 x [N]  write; req_wdata_i  input  SramDw x [N]  write data; req_wmask_i  input  SramDw x [N]  bit write mask.
REQ-008 SHALL have port gnt_o  output  N  one-hot grant, same cycle as request.
REQ-009 SHALL have ports rsp_rvalid_o  output  N  one-hot read-response pulse; rsp_rdata_o  output  SramDw x [N]; rsp_error_o  output  2 x [N].
REQ-010 SHALL have ports sram_req_o  output  1; sram_addr_o  output  SramAw; sram_write_o  output  1; sram_wdata_o  output  SramDw; sram_wmask_o  output  SramDw.
REQ-011 SHALL have ports sram_rvalid_i  input  1; sram_rdata_i  input  SramDw; sram_rerror_i  input  2.
REQ-012 SHALL have port outstanding_o  output  CntW  reads issued and not yet returned.
REQ-013 SHALL have port err_o  output  1  sticky protocol error (present only per REQ-030).

Function
REQ-014 SHALL arbitrate round-robin: a priority pointer p; grant the first eligible requester at index p, p+1, ..., wrapping at N-1 to 0.
REQ-015 SHALL treat a requester as eligible when req_i[i]=1 and (req_write_i[i]=1 or read slot available).
REQ-016 SHALL define read slot available as count < Outstanding, or count == Outstanding with a read response popping in the same cycle.
REQ-017 SHALL drive sram_req_o = |gnt_o and route the granted port's addr/write/wdata/wmask to the sram_* outputs combinationally; sram_* data outputs SHALL be 0 when no grant.
REQ-018 SHALL update p to (granted index + 1) mod N on the clock edge after a grant; p SHALL hold when no grant.
REQ-019 SHALL push the one-hot gnt_o into an Outstanding-deep steering FIFO on each granted read; writes SHALL NOT push and receive no response.
REQ-020 SHALL pop the FIFO head when sram_rvalid_i=1 and FIFO non-empty; rsp_rvalid_o = head & {N{sram_rvalid_i}} in that same cycle (zero added latency).
REQ-021 SHALL broadcast sram_rdata_i and sram_rerror_i to every rsp_rdata_o[i] / rsp_error_o[i].
REQ-022 SHALL allow simultaneous push and pop in one cycle including when full (count unchanged) and when empty with same-cycle grant (no bypass: push lands, pop does not occur from empty).
REQ-023 SHALL ignore sram_rvalid_i while FIFO empty: no rsp_rvalid_o pulse, count unchanged.
REQ-024 SHALL maintain outstanding_o = FIFO occupancy: +1 push-only, -1 pop-only, unchanged otherwise; never exceeds Outstanding.
REQ-025 SHALL block reads from all ports (writes still granted) while count == Outstanding and no pop occurs.
REQ-026 SHALL wrap FIFO read/write pointers modulo Outstanding for any Outstanding value, power of two or not.

Reset
REQ-027 SHALL, on rst_ni low, asynchronously clear p to 0, FIFO pointers and count to 0, err_o to 0.
REQ-028 SHALL drive, during reset, gnt_o and rsp_rvalid_o to 0 and outstanding_o to 0; in-flight reads are discarded.
REQ-029 SHALL resume arbitration on the first rising clk_i edge after rst_ni deasserts with p = 0.

Configuration
REQ-030 SHALL, with macro PRIM_SRAM_ARB_ERR_CHECK_EN defined, provide err_o: set on sram_rvalid_i with empty FIFO, held until reset; without it, err_o SHALL be absent and the unexpected-rvalid case only dropped per REQ-023.

Verification
REQ-031 SHALL cover: req_i=4'b1111, all reads, sram_rvalid_i held 0, Outstanding=4 -> grants 0,1,2,3 in successive cycles, then gnt_o=0, outstanding_o=4.
REQ-032 SHALL cover: outstanding_o=4, port 1 write and port 2 read together -> gnt_o=4'b0010 with sram_write_o=1; port 2 waits.
REQ-033 SHALL cover: reads from ports 2 then 0 issued, sram_rvalid_i pulses twice with data 0xA5A5_0001, 0xA5A5_0002 -> rsp_rvalid_o=4'b0100 then 4'b0001, same cycles, correct data.
REQ-034 SHALL cover: full FIFO, sram_rvalid_i=1 and new read request same cycle -> read granted, outstanding_o stays 4.
REQ-035 SHALL cover: sram_rvalid_i=1 with outstanding_o=0 -> rsp_rvalid_o=0; with PRIM_SRAM_ARB_ERR_CHECK_EN err_o=1 next cycle and holds until rst_ni low.
REQ-036 SHALL cover: rst_ni low mid-traffic with 3 reads outstanding -> outputs 0 immediately, outstanding_o=0, first grant after reset goes to lowest requesting index.
